// File: rtl/frame_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_pkg : shared frame layout, addresses and receiver FSM states          |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
package frame_pkg;

  localparam int FRAME_W = 16;

  localparam logic [3:0] SFD   = 4'b0101;
  localparam logic [3:0] MAC_A = 4'hA;
  localparam logic [3:0] MAC_B = 4'hB;
  localparam logic [3:0] MAC_C = 4'hC;
  localparam logic [3:0] MAC_D = 4'hD;
  localparam logic [3:0] BCAST = 4'hF;

  localparam int SFD_MSB = 15;
  localparam int SFD_LSB = 12;
  localparam int DST_MSB = 11;
  localparam int DST_LSB = 8;
  localparam int SRC_MSB = 7;
  localparam int SRC_LSB = 4;
  localparam int PAY_MSB = 3;
  localparam int PAY_LSB = 0;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CHECK = 2'd2
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/frame_rx_deser_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rx_fifo : synchronous FIFO with registered head, count, full and empty      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module rx_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             w_empty, w_full, w_pop, w_push;

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == FULL_CNT);
  assign w_pop   = pop_i && !w_empty;
  // A full FIFO still takes a push when a pop frees the head slot in the same cycle.
  assign w_push  = push_i && (!w_full || w_pop);

  always_comb begin
    wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (w_push && !w_pop)      count_d = count_q + 1'b1;
    else if (w_pop && !w_push) count_d = count_q - 1'b1;
    dout_d   = w_empty ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst && w_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  assign dout_o  = dout_q;
  assign empty_o = w_empty;
  assign full_o  = w_full;
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/frame_rx_deser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_rx_deser : SFD hunt, 16-bit frame deserializer, address filter and    |
// |                  receive FIFO. FRAME_RX_BCAST_EN also accepts DST 4'hF.      |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
module frame_rx_deser
  import frame_pkg::*;
#(
  parameter logic [3:0] MAC_ADDRESS = 4'hA,
  parameter int         FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_bit,
  output logic [FRAME_W-1:0]            rx_frame,
  output logic                          frame_rx_valid,
  input  logic                          fifo_rd_en,
  output logic [FRAME_W-1:0]            fifo_dout,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    rx_ok_cnt,
  output logic [7:0]                    rx_drop_cnt
);

  rx_state_e        state_q, state_d;
  logic [2:0]       win_q, win_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [FRAME_W-1:0] rx_frame_q, rx_frame_d;
  logic             valid_q;
  logic [7:0]       ok_q, ok_d, drop_q, drop_d;

  logic [3:0]       w_window, w_dst, w_src;
  logic             w_check, w_dst_ok, w_accept, w_stored, w_dropped;

  assign w_window = {win_q, rx_bit};
  assign w_dst    = shreg_q[DST_MSB:DST_LSB];
  assign w_src    = shreg_q[SRC_MSB:SRC_LSB];
  assign w_check  = (state_q == ST_CHECK);

`ifdef FRAME_RX_BCAST_EN
  assign w_dst_ok = (w_dst == MAC_ADDRESS) || (w_dst == BCAST);
`else
  assign w_dst_ok = (w_dst == MAC_ADDRESS);
`endif

  assign w_accept  = w_check && w_dst_ok && (w_src != MAC_ADDRESS);
  assign w_stored  = w_accept && (!fifo_full || fifo_rd_en);
  assign w_dropped = (w_check && !w_accept) || (w_accept && !w_stored);

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    rx_frame_d = w_accept ? shreg_q : rx_frame_q;
    ok_d       = (w_stored  && ok_q   != 8'hFF) ? ok_q + 8'd1   : ok_q;
    drop_d     = (w_dropped && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    case (state_q)
      ST_HUNT: begin
        win_d = w_window[2:0];
        if (w_window == SFD) begin
          shreg_d  = FRAME_W'(SFD);
          bitcnt_d = 4'd0;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        shreg_d  = {shreg_q[FRAME_W-2:0], rx_bit};
        bitcnt_d = bitcnt_q + 4'd1;
        if (bitcnt_q == 4'd11) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        // Clearing the window keeps the frame tail from matching a fresh SFD.
        win_d   = 3'd0;
        state_d = ST_HUNT;
      end
      default: begin
        win_d   = 3'd0;
        state_d = ST_HUNT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_HUNT;
      win_q      <= 3'd0;
      shreg_q    <= '0;
      bitcnt_q   <= 4'd0;
      rx_frame_q <= '0;
      valid_q    <= 1'b0;
      ok_q       <= 8'd0;
      drop_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      rx_frame_q <= rx_frame_d;
      valid_q    <= w_accept;
      ok_q       <= ok_d;
      drop_q     <= drop_d;
    end
  end

  rx_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_accept),
    .pop_i   (fifo_rd_en),
    .din_i   (shreg_q),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign rx_frame       = rx_frame_q;
  assign frame_rx_valid = valid_q;
  assign rx_ok_cnt      = ok_q;
  assign rx_drop_cnt    = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_rx_deser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_frame_rx_deser : directed and random frames against a queue-based model  |
// | Revision          : 1.0                                                     |
// +----------------------------------------------------------------------------+
module tb_frame_rx_deser;

  localparam logic [3:0] MAC = 4'hB;

  logic        clk, rst, rx_bit, fifo_rd_en;
  logic [15:0] rx_frame, fifo_dout;
  logic        frame_rx_valid, fifo_empty, fifo_full;
  logic [2:0]  fifo_count;
  logic [7:0]  rx_ok_cnt, rx_drop_cnt;

  frame_rx_deser #(.MAC_ADDRESS(MAC), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_bit         (rx_bit),
    .rx_frame       (rx_frame),
    .frame_rx_valid (frame_rx_valid),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_dout      (fifo_dout),
    .fifo_empty     (fifo_empty),
    .fifo_full      (fifo_full),
    .fifo_count     (fifo_count),
    .rx_ok_cnt      (rx_ok_cnt),
    .rx_drop_cnt    (rx_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] q[$];
  int          exp_ok, exp_drop;
  logic [15:0] exp_rx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_accept(input logic [15:0] f);
    bit dst_ok;
    dst_ok = (f[11:8] == MAC);
`ifdef FRAME_RX_BCAST_EN
    if (f[11:8] == 4'hF) dst_ok = 1'b1;
`endif
    return dst_ok && (f[7:4] != MAC);
  endfunction

  task automatic model_reset();
    q.delete();
    exp_ok = 0; exp_drop = 0; exp_rx = 16'h0000;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
    chk({tag, "_empty"}, 32'(fifo_empty), 32'(q.size() == 0));
    chk({tag, "_full"},  32'(fifo_full),  32'(q.size() == 4));
    chk({tag, "_dout"},  32'(fifo_dout),  32'(q.size() != 0 ? q[0] : 16'h0000));
    chk({tag, "_ok"},    32'(rx_ok_cnt),  32'(exp_ok));
    chk({tag, "_drop"},  32'(rx_drop_cnt), 32'(exp_drop));
    chk({tag, "_rxfrm"}, 32'(rx_frame),   32'(exp_rx));
  endtask

  // Last bit sampled at edge N; valid expected only in the cycle after edge N+1.
  task automatic send_frame(input string tag, input logic [15:0] f,
                            input bit pop_at_check, input bit check_bit);
    bit acc, popping, full_before;
    for (int i = 15; i >= 0; i--) begin
      rx_bit = f[i];
      tick();
    end
    chk({tag, "_vearly"}, 32'(frame_rx_valid), 32'd0);
    rx_bit      = check_bit;
    fifo_rd_en  = pop_at_check;
    acc         = model_accept(f);
    full_before = (q.size() == 4);
    popping     = pop_at_check && (q.size() != 0);
    tick();
    rx_bit     = 1'b0;
    fifo_rd_en = 1'b0;
    if (popping) void'(q.pop_front());
    if (acc) begin
      exp_rx = f;
      if (!full_before || popping) begin
        q.push_back(f);
        exp_ok = (exp_ok < 255) ? exp_ok + 1 : 255;
      end else begin
        exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
      end
    end else begin
      exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
    end
    chk({tag, "_vpulse"}, 32'(frame_rx_valid), 32'(acc));
    tick();
    chk({tag, "_vonce"}, 32'(frame_rx_valid), 32'd0);
    check_state(tag);
  endtask

  task automatic pop(input string tag);
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    tick();
    check_state(tag);
  endtask

  task automatic idle(input int n);
    rx_bit = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    logic [15:0] f;
    logic [3:0]  d;
    rst = 1'b0; rx_bit = 1'b0; fifo_rd_en = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("rst_valid", 32'(frame_rx_valid), 32'd0);
    check_state("rst");
    rst = 1'b1;
    idle(8);

    // Basic accept
    send_frame("f5BA7", 16'h5BA7, 1'b0, 1'b0);
    pop("pop_5BA7");
    pop("pop_empty");

    // DST mismatch and loopback
    send_frame("dstmis", 16'h5CA7, 1'b0, 1'b0);
    idle(2);
    send_frame("loopbk", 16'h5BB3, 1'b0, 1'b0);

    // Overflow: five frames, no pops
    for (int p = 1; p <= 5; p++) begin
      f = 16'h5BA0 | 16'(p);
      send_frame("ovf", f, 1'b0, 1'b0);
    end
    for (int p = 1; p <= 4; p++) pop("ovf_pop");

    // Full with simultaneous pop and push
    for (int p = 6; p <= 9; p++) send_frame("fill", 16'h5BA0 | 16'(p), 1'b0, 1'b0);
    send_frame("fullpp", 16'h5BAE, 1'b1, 1'b0);
    for (int p = 0; p < 4; p++) pop("fullpp_pop");

    // Reset after 6 bits of a frame
    f = 16'h5BA1;
    for (int i = 15; i >= 10; i--) begin
      rx_bit = f[i];
      tick();
    end
    rst = 1'b0; rx_bit = 1'b0;
    tick(); tick();
    rst = 1'b1;
    model_reset();
    tick();
    check_state("midrst");
    send_frame("clean", 16'h5BA3, 1'b0, 1'b0);

    // Broadcast destination
    send_frame("bcast", 16'h5FA2, 1'b0, 1'b0);
    pop("bc_pop");
    pop("bc_pop2");

    // Random traffic, including noise on the CHECK-cycle bit
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0, 1:    d = MAC;
        2:       d = 4'hC;
        3:       d = 4'hF;
        default: d = 4'($urandom_range(0, 15));
      endcase
      f = {4'b0101, d, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      send_frame("rnd", f, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) pop("rnd_pop");
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 5));
    end

    // Drop counter saturation
    for (int k = 0; k < 260; k++) send_frame("sat", 16'h5CA0, 1'b0, 1'b0);
    chk("sat_drop", 32'(rx_drop_cnt), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
